// File: rtl/em_stage_reg.sv
// EX/MEM pipeline stage register with dcache request tracking (IDLE/WAIT/DONE).
// Define EM_STALL_CNT_EN to build the per-instruction WAIT-cycle counter; otherwise stall_cnt is 0.
module em_stage_reg #(
  parameter int PAYLOAD_W = 96,
  parameter int CNT_W     = 16
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 ihit,
  input  logic                 dhit,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic                 in_ren,
  input  logic                 in_wen,
  input  logic                 in_atomic,
  output logic                 out_valid,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic                 dmemREN,
  output logic                 dmemWEN,
  output logic                 out_atomic,
  output logic                 mem_busy,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [1:0]           o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 r_state;
  logic                   r_valid;
  logic [PAYLOAD_W-1:0]   r_payload;
  logic                   r_ren;
  logic                   r_wen;
  logic                   r_atomic;
  logic                   w_adv;
  logic                   w_flush;
  logic                   w_req_load;

  // Handshake: the stage advances on ihit unless a request is outstanding;
  // an outstanding request completes in any cycle dhit is high.
  assign w_adv      = ihit && (r_state != WAIT || dhit);
  assign w_flush    = flush && ihit;
  assign w_req_load = in_valid && (in_ren || in_wen);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state   <= IDLE;
      r_valid   <= 1'b0;
      r_payload <= '0;
      r_ren     <= 1'b0;
      r_wen     <= 1'b0;
      r_atomic  <= 1'b0;
    end else if (w_flush) begin
      r_state   <= IDLE;
      r_valid   <= 1'b0;
      r_payload <= '0;
      r_ren     <= 1'b0;
      r_wen     <= 1'b0;
      r_atomic  <= 1'b0;
    end else if (w_adv) begin
      r_state   <= w_req_load ? WAIT : IDLE;
      r_valid   <= in_valid;
      r_payload <= in_payload;
      r_ren     <= in_valid && in_ren;
      r_wen     <= in_valid && in_wen;
      r_atomic  <= in_valid && in_atomic;
    end else if (r_state == WAIT && dhit) begin
      // Completed without ihit: drop the request but keep the instruction.
      r_state   <= DONE;
      r_ren     <= 1'b0;
      r_wen     <= 1'b0;
      r_atomic  <= 1'b0;
    end
  end

`ifdef EM_STALL_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_stall_cnt <= '0;
    end else if (w_flush || w_adv) begin
      r_stall_cnt <= '0;
    end else if (r_state == WAIT && !dhit && r_stall_cnt != {CNT_W{1'b1}}) begin
      r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif

  assign out_valid   = r_valid;
  assign out_payload = r_payload;
  assign dmemREN     = r_ren;
  assign dmemWEN     = r_wen;
  assign out_atomic  = r_atomic;
  assign mem_busy    = (r_state == WAIT);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_em_stage_reg.sv
// Bench for em_stage_reg: directed scenarios plus randomized traffic against a request-level model.
module tb_em_stage_reg;

  localparam int PW = 96;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          ihit = 1'b0, dhit = 1'b0, flush = 1'b0;
  logic          in_valid = 1'b0, in_ren = 1'b0, in_wen = 1'b0, in_atomic = 1'b0;
  logic [PW-1:0] in_payload = '0;

  logic          out_valid, dmemREN, dmemWEN, out_atomic, mem_busy;
  logic [PW-1:0] out_payload;
  logic [15:0]   stall_cnt;
  logic [1:0]    dbg_state;
  logic          s_out_valid, s_dmemREN, s_dmemWEN, s_out_atomic, s_mem_busy;
  logic [PW-1:0] s_out_payload;
  logic [3:0]    s_stall_cnt;
  logic [1:0]    s_dbg_state;

  em_stage_reg #(.PAYLOAD_W(PW), .CNT_W(16)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .flush(flush),
    .in_valid(in_valid), .in_payload(in_payload), .in_ren(in_ren), .in_wen(in_wen),
    .in_atomic(in_atomic), .out_valid(out_valid), .out_payload(out_payload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .out_atomic(out_atomic),
    .mem_busy(mem_busy), .stall_cnt(stall_cnt), .o_dbg_state(dbg_state)
  );

  em_stage_reg #(.PAYLOAD_W(PW), .CNT_W(4)) dut_small (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .flush(flush),
    .in_valid(in_valid), .in_payload(in_payload), .in_ren(in_ren), .in_wen(in_wen),
    .in_atomic(in_atomic), .out_valid(s_out_valid), .out_payload(s_out_payload),
    .dmemREN(s_dmemREN), .dmemWEN(s_dmemWEN), .out_atomic(s_out_atomic),
    .mem_busy(s_mem_busy), .stall_cnt(s_stall_cnt), .o_dbg_state(s_dbg_state)
  );

  // clock / reset
  always #5 CLK = ~CLK;

`ifdef EM_STALL_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  int n_chk = 0;
  int n_pass = 0;

  // reference model: the instruction held in the stage and its outstanding request
  logic          m_valid, m_ren, m_wen, m_atomic;
  logic [PW-1:0] m_payload;
  int            m_cnt16, m_cnt4;

  function automatic void model_clear();
    m_valid = 0; m_ren = 0; m_wen = 0; m_atomic = 0; m_payload = '0;
    m_cnt16 = 0; m_cnt4 = 0;
  endfunction

  function automatic int exp_cnt16();
    return CNT_ON ? m_cnt16 : 0;
  endfunction

  function automatic int exp_cnt4();
    return CNT_ON ? m_cnt4 : 0;
  endfunction

  // driver tasks
  task automatic drive(input logic v, input logic r, input logic w, input logic a,
                       input logic [PW-1:0] p, input logic ih, input logic dh, input logic fl);
    in_valid = v; in_ren = r; in_wen = w; in_atomic = a; in_payload = p;
    ihit = ih; dhit = dh; flush = fl;
  endtask

  // One clock: the model consumes the inputs present at the edge; returns at the next negedge.
  task automatic step();
    logic outstanding, advance;
    @(posedge CLK);
    outstanding = m_ren || m_wen;
    advance = ihit && (!outstanding || dhit);
    if (flush && ihit) begin
      model_clear();
    end else if (advance) begin
      m_valid = in_valid; m_payload = in_payload;
      m_ren = in_valid & in_ren; m_wen = in_valid & in_wen; m_atomic = in_valid & in_atomic;
      m_cnt16 = 0; m_cnt4 = 0;
    end else if (outstanding && dhit) begin
      m_ren = 0; m_wen = 0; m_atomic = 0;
    end else if (outstanding) begin
      if (m_cnt16 < 65535) m_cnt16++;
      if (m_cnt4 < 15) m_cnt4++;
    end
    @(negedge CLK);
  endtask

  function automatic logic [PW-1:0] rand_payload();
    return {$urandom, $urandom, $urandom};
  endfunction

  task automatic test_reset();
    logic [PW-1:0] p;
    p = rand_payload();
    nRST = 1'b0;
    drive(0, 0, 0, 0, '0, 0, 0, 0);
    @(negedge CLK);
    n_chk++; if ({out_valid, dmemREN, dmemWEN, out_atomic, mem_busy} !== 5'b0 || stall_cnt !== 16'd0)
      $display("FAIL reset_init got v%b r%b w%b a%b b%b cnt%0d exp all 0", out_valid, dmemREN, dmemWEN, out_atomic, mem_busy, stall_cnt);
    else n_pass++;
    nRST = 1'b1;
    model_clear();
    @(negedge CLK);
    drive(1, 1, 0, 0, p, 1, 0, 0);
    step();
    drive(0, 0, 0, 0, '0, 0, 0, 0);
    n_chk++; if (dmemREN !== 1'b1 || mem_busy !== 1'b1)
      $display("FAIL reset_preload got ren %b busy %b exp 1 1", dmemREN, mem_busy);
    else n_pass++;
    #2 nRST = 1'b0;
    #1;
    n_chk++; if ({out_valid, dmemREN, dmemWEN, out_atomic, mem_busy} !== 5'b0 || out_payload !== '0)
      $display("FAIL reset_async got v%b r%b w%b a%b b%b exp all 0", out_valid, dmemREN, dmemWEN, out_atomic, mem_busy);
    else n_pass++;
    model_clear();
    @(negedge CLK);
    nRST = 1'b1;
    step();
    n_chk++; if (mem_busy !== 1'b0 || dmemREN !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL reset_release got busy %b ren %b valid %b exp 0 0 0", mem_busy, dmemREN, out_valid);
    else n_pass++;
  endtask

  task automatic test_load_miss();
    logic [PW-1:0] p, p2;
    p = 96'hDEAD_BEEF_0123_4567_89AB_CDEF;
    p2 = rand_payload();
    drive(1, 1, 0, 0, p, 1, 0, 0);
    step();
    drive(0, 0, 0, 0, '0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      n_chk++; if (dmemREN !== 1'b1 || out_payload !== p)
        $display("FAIL miss_wait%0d got ren %b payload %h exp 1 %h", i, dmemREN, out_payload, p);
      else n_pass++;
      step();
    end
    drive(0, 0, 0, 0, '0, 0, 1, 0);
    n_chk++; if (dmemREN !== 1'b1 || stall_cnt !== 16'(CNT_ON ? 5 : 0))
      $display("FAIL miss_6th got ren %b cnt %0d exp 1 %0d", dmemREN, stall_cnt, CNT_ON ? 5 : 0);
    else n_pass++;
    step();
    n_chk++; if (dmemREN !== 1'b0 || mem_busy !== 1'b0 || out_payload !== p || out_valid !== 1'b1 ||
                 stall_cnt !== 16'(exp_cnt16()))
      $display("FAIL miss_done got ren %b busy %b valid %b cnt %0d exp 0 0 1 %0d", dmemREN, mem_busy, out_valid, stall_cnt, exp_cnt16());
    else n_pass++;
    drive(1, 0, 0, 0, p2, 0, 1, 0);
    step();
    n_chk++; if (out_payload !== p || dmemREN !== 1'b0)
      $display("FAIL miss_done_hold got payload %h ren %b exp %h 0", out_payload, dmemREN, p);
    else n_pass++;
    drive(1, 0, 0, 0, p2, 1, 0, 0);
    step();
    n_chk++; if (out_payload !== p2 || mem_busy !== 1'b0 || stall_cnt !== 16'd0)
      $display("FAIL miss_next got payload %h busy %b cnt %0d exp %h 0 0", out_payload, mem_busy, stall_cnt, p2);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [PW-1:0] p1, p2;
    p1 = rand_payload(); p2 = rand_payload();
    drive(1, 0, 1, 0, p1, 1, 0, 0);
    step();
    drive(1, 0, 1, 0, p2, 0, 0, 0);
    step();
    n_chk++; if (dmemWEN !== 1'b1 || out_payload !== p1)
      $display("FAIL b2b_first got wen %b payload %h exp 1 %h", dmemWEN, out_payload, p1);
    else n_pass++;
    drive(1, 0, 1, 0, p2, 1, 1, 0);
    step();
    n_chk++; if (dmemWEN !== 1'b1 || out_payload !== p2 || mem_busy !== 1'b1)
      $display("FAIL b2b_second got wen %b busy %b payload %h exp 1 1 %h", dmemWEN, mem_busy, out_payload, p2);
    else n_pass++;
    drive(0, 0, 0, 0, '0, 0, 1, 0);
    step();
    n_chk++; if (dmemWEN !== 1'b0 || out_valid !== 1'b1)
      $display("FAIL b2b_complete got wen %b valid %b exp 0 1", dmemWEN, out_valid);
    else n_pass++;
  endtask

  task automatic test_flush();
    logic [PW-1:0] p;
    p = rand_payload();
    drive(1, 1, 0, 1, p, 1, 0, 0);
    step();
    drive(0, 0, 0, 0, '0, 0, 0, 1);
    step();
    n_chk++; if (dmemREN !== 1'b1 || mem_busy !== 1'b1 || out_payload !== p)
      $display("FAIL flush_noihit got ren %b busy %b payload %h exp 1 1 %h", dmemREN, mem_busy, out_payload, p);
    else n_pass++;
    drive(1, 1, 1, 1, rand_payload(), 1, 0, 1);
    step();
    n_chk++; if ({out_valid, dmemREN, dmemWEN, out_atomic, mem_busy} !== 5'b0 || out_payload !== '0 || stall_cnt !== 16'd0)
      $display("FAIL flush_wait got v%b r%b w%b a%b b%b cnt %0d exp all 0", out_valid, dmemREN, dmemWEN, out_atomic, mem_busy, stall_cnt);
    else n_pass++;
  endtask

  task automatic test_atomic();
    logic [PW-1:0] p;
    p = rand_payload();
    drive(1, 1, 0, 1, p, 1, 0, 0);
    step();
    n_chk++; if (out_atomic !== 1'b1 || dmemREN !== 1'b1)
      $display("FAIL atomic_issue got atomic %b ren %b exp 1 1", out_atomic, dmemREN);
    else n_pass++;
    drive(0, 0, 0, 0, '0, 0, 1, 0);
    step();
    n_chk++; if (out_atomic !== 1'b0 || dmemREN !== 1'b0 || out_valid !== 1'b1)
      $display("FAIL atomic_done got atomic %b ren %b valid %b exp 0 0 1", out_atomic, dmemREN, out_valid);
    else n_pass++;
  endtask

  task automatic test_bubble_saturation();
    drive(0, 1, 1, 1, rand_payload(), 1, 0, 0);
    step();
    n_chk++; if (dmemWEN !== 1'b0 || dmemREN !== 1'b0 || out_valid !== 1'b0 || mem_busy !== 1'b0)
      $display("FAIL bubble got wen %b ren %b valid %b busy %b exp 0 0 0 0", dmemWEN, dmemREN, out_valid, mem_busy);
    else n_pass++;
    drive(1, 1, 0, 0, rand_payload(), 1, 0, 0);
    step();
    drive(0, 0, 0, 0, '0, 0, 0, 0);
    repeat (20) step();
    n_chk++; if (s_stall_cnt !== 4'(CNT_ON ? 15 : 0))
      $display("FAIL sat_cnt4 got %0d exp %0d", s_stall_cnt, CNT_ON ? 15 : 0);
    else n_pass++;
    n_chk++; if (stall_cnt !== 16'(CNT_ON ? 20 : 0))
      $display("FAIL sat_cnt16 got %0d exp %0d", stall_cnt, CNT_ON ? 20 : 0);
    else n_pass++;
    drive(0, 0, 0, 0, '0, 1, 1, 0);
    step();
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 1), rand_payload(), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) == 0));
      step();
      n_chk++;
      if (out_valid !== m_valid || out_payload !== m_payload || dmemREN !== m_ren ||
          dmemWEN !== m_wen || out_atomic !== m_atomic || mem_busy !== (m_ren | m_wen) ||
          stall_cnt !== 16'(exp_cnt16()) || s_stall_cnt !== 4'(exp_cnt4()) ||
          s_out_payload !== m_payload || s_dmemREN !== m_ren || s_dmemWEN !== m_wen) begin
        if (errs < 10)
          $display("FAIL rand cyc %0d got v%b r%b w%b a%b b%b c%0d c4 %0d exp v%b r%b w%b a%b b%b c%0d c4 %0d",
                   i, out_valid, dmemREN, dmemWEN, out_atomic, mem_busy, stall_cnt, s_stall_cnt,
                   m_valid, m_ren, m_wen, m_atomic, m_ren | m_wen, exp_cnt16(), exp_cnt4());
        errs++;
      end else n_pass++;
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_load_miss();
    test_back_to_back();
    test_flush();
    test_atomic();
    test_bubble_saturation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
